// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: expands a 128-bit cipher key into eleven round keys,
// one per clock, and holds them in a buffer behind a registered read port.
//
// Handshake: key_valid is a level from upstream. Its rising edge (key_valid=1
// while the registered copy is 0) starts a run, in any state. Dropping it sends
// the FSM to IDLE. There is no back-pressure. rk_valid is a one-cycle,
// registered pulse per written key, qualifying rk_idx/rk_out in that cycle.

// Combinational AES S-box, built from the GF(2^8) inverse (x^254) and the
// affine transform.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] pow_q;
    logic [7:0] inv;

    // x^127 by square-and-multiply, one more square gives x^254 = x^-1 (0 -> 0)
    always_comb begin
        pow_q = in_i;
        for (int i = 0; i < 6; i++) pow_q = gf_mul(gf_mul(pow_q, pow_q), in_i);
        inv   = gf_mul(pow_q, pow_q);
        out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expansion (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    input  logic [3:0]   rk_rd_addr,
    output logic [127:0] rk_rd_data,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         busy,
    output logic         done,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic         kv_q;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_rd_data_q;
    logic         rk_valid_q;
    logic [3:0]   rk_idx_q;
    logic [127:0] rk_out_q;

    logic         start;
    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [127:0] wr_data;

    logic [3:0]   prev_idx;
    logic [127:0] prev_key;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [7:0]   rcon;
    logic [31:0]  t_word, n0, n1, n2, n3;
    logic [127:0] next_key;

    assign start = key_valid & ~kv_q;

    // Round constant for the round being produced
    always_comb begin
        rcon = 8'h00;
        case (cnt_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Fetch the previous round key and rotate its last word
    always_comb begin
        prev_idx = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
        prev_key = rk_q[prev_idx];
        rot_word = {prev_key[23:0], prev_key[31:24]};
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (rot_word[8*g +: 8]),
            .out_o (sub_word[8*g +: 8])
        );
    end

    // Word chain of the key schedule
    always_comb begin
        t_word   = sub_word ^ {rcon, 24'h000000};
        n0       = prev_key[127:96] ^ t_word;
        n1       = prev_key[95:64]  ^ n0;
        n2       = prev_key[63:32]  ^ n1;
        n3       = prev_key[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Next-state, counter and buffer write control; start beats abort beats run
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        wr_data = next_key;
        if (start) begin
            state_d = ST_EXPAND;
            cnt_d   = 4'd1;
            wr_en   = 1'b1;
            wr_idx  = 4'd0;
            wr_data = key_in;
        end else if (!key_valid) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_EXPAND) begin
            wr_en = 1'b1;
            if (cnt_q == 4'd10) state_d = ST_DONE;
            else                cnt_d   = cnt_q + 4'd1;
        end
    end

    // State, counter, key buffer and write-report registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            kv_q       <= 1'b0;
            cnt_q      <= 4'd0;
            rk_valid_q <= 1'b0;
            rk_idx_q   <= 4'd0;
            rk_out_q   <= '0;
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            kv_q       <= key_valid;
            cnt_q      <= cnt_d;
            rk_valid_q <= wr_en;
            if (wr_en) begin
                rk_q[wr_idx] <= wr_data;
                rk_idx_q     <= wr_idx;
                rk_out_q     <= wr_data;
            end
        end
    end

    // Registered read port; out-of-range indices read as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rk_rd_data_q <= '0;
        end else if (rk_rd_addr <= 4'd10) begin
            rk_rd_data_q <= rk_q[rk_rd_addr];
        end else begin
            rk_rd_data_q <= '0;
        end
    end

    assign rk_rd_data = rk_rd_data_q;
    assign rk_valid   = rk_valid_q;
    assign rk_idx     = rk_idx_q;
    assign rk_out     = rk_out_q;
    assign busy       = (state_q == ST_EXPAND);
    assign done       = (state_q == ST_DONE);
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: table-driven known-answer runs,
// abort, reset mid-run and level-hold sequences, with a round-key scoreboard.
module tb_aes_key_expansion;
    logic         clk;
    logic         reset;
    logic [127:0] key_in;
    logic         key_valid;
    logic [3:0]   rk_rd_addr;
    logic [127:0] rk_rd_data;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [131:0] exp_q[$];
    logic [127:0] mk      [0:10];
    logic [127:0] mk_prev [0:10];
    logic [127:0] sbox_rows [0:15];

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;
    vec_t vecs [0:1];

    aes_key_expansion dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .rk_rd_addr (rk_rd_addr),
        .rk_rd_data (rk_rd_data),
        .rk_valid   (rk_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference S-box table lookup
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        row = sbox_rows[b[7:4]];
        return row[8*(15 - int'(b[3:0])) +: 8];
    endfunction

    function automatic logic [7:0] rcon_of(input int r);
        case (r)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] model_next(input logic [127:0] p, input int r);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        {w0, w1, w2, w3} = p;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon_of(r), 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    task automatic compute_model(input logic [127:0] key);
        mk[0] = key;
        for (int r = 1; r <= 10; r++) mk[r] = model_next(mk[r-1], r);
    endtask

    task automatic push_range(input int count);
        for (int i = 0; i < count; i++) exp_q.push_back({4'(i), mk[i]});
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Inputs change 2 time units after the active edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard consumer: every rk_valid pulse must match the queue head
    task automatic monitor();
        logic [131:0] e;
        forever begin
            @(negedge clk);
            if (rk_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rk_valid_unexpected", {127'd0, rk_valid}, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rk_idx", {124'd0, rk_idx}, {124'd0, e[131:128]});
                    check("rk_out", rk_out, e[127:0]);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rk_valid"},   {127'd0, rk_valid},  128'd0);
        check({tag, "_rk_idx"},     {124'd0, rk_idx},    128'd0);
        check({tag, "_rk_out"},     rk_out,              128'd0);
        check({tag, "_busy"},       {127'd0, busy},      128'd0);
        check({tag, "_done"},       {127'd0, done},      128'd0);
        check({tag, "_rk_rd_data"}, rk_rd_data,          128'd0);
        check({tag, "_state"},      {126'd0, dbg_state}, 128'd0);
    endtask

    // Runs 13 cycles after a start; returns busy-cycle count and done edge
    task automatic run_timing(output int busy_cnt, output int done_at,
                              output logic [127:0] got1, output logic [127:0] got10);
        busy_cnt = 0;
        done_at  = -1;
        got1     = '0;
        got10    = '0;
        for (int k = 0; k < 13; k++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1 && done_at < 0) done_at = k;
            if (rk_valid === 1'b1 && rk_idx == 4'd1)  got1  = rk_out;
            if (rk_valid === 1'b1 && rk_idx == 4'd10) got10 = rk_out;
        end
    endtask

    int           busy_cnt, done_at, done_drops;
    logic [127:0] got1, got10, rkey;

    initial begin
        sbox_rows = '{
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        vecs[0] = '{key:  128'h00000000000000000000000000000000,
                    rk1:  128'h62636363626363636263636362636363,
                    rk10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[1] = '{key:  128'h2b7e151628aed2a6abf7158809cf4f3c,
                    rk1:  128'ha0fafe1788542cb123a339392a6c7605,
                    rk10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        for (int i = 0; i < 11; i++) mk[i] = '0;

        // Reset
        reset      = 1'b0;
        key_valid  = 1'b0;
        key_in     = '0;
        rk_rd_addr = 4'd0;
        fork
            monitor();
        join_none
        #3;
        check_all_zero("reset");
        tick();
        reset = 1'b1;
        tick();

        // Known-answer vectors: full run, timing, read port
        for (int v = 0; v < 2; v++) begin
            key_valid = 1'b0;
            tick();
            check("idle_after_drop_state", {126'd0, dbg_state}, 128'd0);
            check("idle_after_drop_done",  {127'd0, done},      128'd0);
            tick();
            compute_model(vecs[v].key);
            key_in = vecs[v].key;
            push_range(11);
            key_valid = 1'b1;
            run_timing(busy_cnt, done_at, got1, got10);
            check("busy_cycles",  128'(busy_cnt), 128'd10);
            check("done_latency", 128'(done_at),  128'd10);
            check("rk1_vector",   got1,  vecs[v].rk1);
            check("rk10_vector",  got10, vecs[v].rk10);
            check("sb_drained",   128'(exp_q.size()), 128'd0);
            for (int a = 0; a <= 12; a++) begin
                if (a == 11) continue;
                rk_rd_addr = 4'(a);
                #1;
                if (a >= 1 && a <= 10) check("read_not_combinational", rk_rd_data, mk[a-1]);
                tick();
                if (a <= 10) check("read_rk", rk_rd_data, mk[a]);
                else         check("read_out_of_range", rk_rd_data, 128'd0);
            end
        end

        // Abort at edge N+4, buffer retention, then FIPS restart
        key_valid = 1'b0;
        tick();
        tick();
        mk_prev = mk;
        rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
        compute_model(rkey);
        key_in = rkey;
        push_range(4);
        key_valid = 1'b1;
        repeat (4) tick();
        key_valid = 1'b0;
        tick();
        check("abort_state", {126'd0, dbg_state}, 128'd0);
        check("abort_done",  {127'd0, done},      128'd0);
        check("abort_busy",  {127'd0, busy},      128'd0);
        check("abort_sb_drained", 128'(exp_q.size()), 128'd0);
        rk_rd_addr = 4'd3;
        tick();
        check("retain_new_rk3", rk_rd_data, mk[3]);
        rk_rd_addr = 4'd4;
        tick();
        check("retain_old_rk4", rk_rd_data, mk_prev[4]);

        mk_prev = mk;
        compute_model(vecs[1].key);
        rk_rd_addr = 4'd0;
        key_in = vecs[1].key;
        push_range(11);
        key_valid = 1'b1;
        tick();
        check("same_edge_read_old", rk_rd_data, mk_prev[0]);
        tick();
        check("read_new_rk0", rk_rd_data, mk[0]);
        repeat (10) tick();
        check("restart_done", {127'd0, done}, 128'd1);
        check("restart_sb_drained", 128'(exp_q.size()), 128'd0);
        rk_rd_addr = 4'd10;
        tick();
        check("restart_rk10", rk_rd_data, vecs[1].rk10);

        // Level hold: no restart while key_valid stays high
        done_drops = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (done !== 1'b1) done_drops++;
        end
        check("hold_done_stays", 128'(done_drops), 128'd0);
        for (int a = 0; a <= 10; a++) begin
            rk_rd_addr = 4'(a);
            tick();
            check("hold_buffer", rk_rd_data, mk[a]);
        end

        // Asynchronous reset mid-expansion, restart on release
        key_valid = 1'b0;
        tick();
        tick();
        rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
        compute_model(rkey);
        key_in = rkey;
        push_range(5);
        key_valid = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        check("midrun_sb_drained", 128'(exp_q.size()), 128'd0);
        push_range(11);
        tick();
        tick();
        reset = 1'b1;
        run_timing(busy_cnt, done_at, got1, got10);
        check("release_busy_cycles",  128'(busy_cnt), 128'd10);
        check("release_done_latency", 128'(done_at),  128'd10);
        check("release_sb_drained",   128'(exp_q.size()), 128'd0);
        check("release_rk10", got10, mk[10]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/aes_key_expansion.md
# aes_key_expansion

Expands the 128-bit PUF-derived key produced by the key generator into the eleven AES-128 round keys and buffers them for the AES datapath. It sits directly downstream of the key generator: its `key_in`/`key_valid` inputs are driven by the generator's `key_out`/`enable`. The cipher core reads round keys by index through a registered read port. Expansion computes one round key per clock.

## Interface
- No parameters. AES-128 only: 10 rounds, 11 round keys.
- `clk` input 1: single clock. All state changes on its rising edge.
- `reset` input 1: asynchronous, active-low. `reset`=0 clears all state immediately.
- `key_in` input 128: cipher key. Bit 127 is the MSB of byte 0 (FIPS-197 order). Sampled only on a start edge.
- `key_valid` input 1: level. High means `key_in` is stable. Held high by upstream once asserted.
- `rk_rd_addr` input 4: round-key read index, 0..10.
- `rk_rd_data` output 128: registered read data for `rk_rd_addr`.
- `rk_valid` output 1: one-cycle pulse when a round key is written to the buffer.
- `rk_idx` output 4: index of the key written when `rk_valid`=1.
- `rk_out` output 128: value of the key written when `rk_valid`=1.
- `busy` output 1: high while expansion is in progress.
- `done` output 1: level. High when all 11 keys are valid in the buffer.

## Operation
- **Internal state**
  - `kv_q`: `key_valid` registered by one cycle.
  - A 4-bit round counter.
  - A buffer of 11×128-bit registers, `rk[0..10]`.
  - A 3-state FSM: IDLE, EXPAND, DONE.
- **Start condition**: `key_valid`=1 and `kv_q`=0 at a clock edge (rising edge of `key_valid`). A start is recognised in any state.
  - On start: `rk[0]`←`key_in`, counter←1, state←EXPAND.
  - On start: `rk_valid`=1, `rk_idx`=0, `rk_out`=`key_in`.
  - A start during EXPAND or DONE discards the run in progress and restarts from `rk[0]`.
- **EXPAND**, per edge, with r = counter:
  - Let w0..w3 be the 32-bit words of `rk[r-1]`, w0 in bits 127:96.
  - t = SubWord(RotWord(w3)) XOR {Rcon[r],24'h0}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - `rk[r]`←{n0,n1,n2,n3}; `rk_valid`=1, `rk_idx`=r, `rk_out`={n0,n1,n2,n3}.
  - If r=10: state←DONE. Otherwise counter←r+1.
- **SubWord**: four instances of the shared combinational AES S-box (8 bit in, 8 bit out).
- **DONE**: `done`=1 and the buffer is held.
- **Abort**: `key_valid`=0 in any state sends the FSM to IDLE at the next edge.
  - `done` and `busy` go to 0.
  - Buffer contents are retained, not cleared.
- **Outputs by state**: `busy`=1 only in EXPAND. `done`=1 only in DONE.
- **Read port**: `rk_rd_data`←`rk[rk_rd_addr]` every edge.
  - Addresses 11..15 return 0.
  - A read of an index written on the same edge returns the old value.
- **Width rules**: all arithmetic is XOR on bit vectors. The counter never exceeds 10.

## Timing
- **Reset values** (`reset`=0): state IDLE, `kv_q`=0, counter=0, all `rk`=0, `rk_rd_data`=0, `rk_valid`=0, `rk_idx`=0, `rk_out`=0, `busy`=0, `done`=0.
- **Expansion latency**, start edge at cycle N:
  - `rk[0]` is written at edge N.
  - `rk[r]` is written at edge N+r.
  - `done` rises after edge N+10.
  - `rk_valid` is high for 11 consecutive cycles, after edges N..N+10.
- **Read latency**: 1 cycle from `rk_rd_addr` to `rk_rd_data`.
- **Reset mid-expansion**: all state is cleared at once. After `reset` is released, a new rising edge of `key_valid` is required. If `key_valid` is already high at release, that counts as a start, because `kv_q`=0 after reset.
- **Level hold**: `key_valid` held high after DONE causes no restart.

## Test plan
- **FIPS-197 vector**
  - Stimulus: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, raise `key_valid`.
  - Required: `rk_idx`=1 gives a0fafe1788542cb123a339392a6c7605; `rk_idx`=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: `done` rises 10 cycles after the start edge; `busy` is high for exactly 10 cycles.
- **All-zero key**
  - Required: `rk[1]`=62636363626363636263636362636363 and `rk[10]`=b4ef5bcb3e92e21123e951cf6f8f188e.
  - Required: reads of addresses 0..10 after `done` match the expected values with 1-cycle latency; address 12 returns 0.
- **Abort**
  - Stimulus: drop `key_valid` at edge N+4, raise it again with the FIPS key.
  - Required: FSM goes to IDLE with `done`=0; the restart produces the full 11 keys, and `rk[10]` is correct.
- **Reset mid-run**
  - Stimulus: assert `reset`=0 asynchronously (between edges) at cycle N+5.
  - Required: all outputs are 0 immediately. After release with `key_valid` still high, expansion restarts at the first edge.
- **Level hold**
  - Stimulus: hold `key_valid` high for 50 cycles after `done`.
  - Required: no further `rk_valid` pulses; `done` stays 1 and the buffer is unchanged.
